// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate
//   AHB-style subordinate backed by a DataWidth x Depth on-chip SRAM.
//   Transfers are pipelined: the address phase of the next transfer may
//   overlap the completing data-phase cycle of the previous one. OKAY
//   transfers insert WaitStates wait cycles. Illegal transfers get the
//   standard two-cycle ERROR response and never touch storage.
//   Illegal means out of range, oversize, or misaligned.
//
// Parameters
//   DataWidth  : data bus width in bits (8, 16, 32 or 64)
//   AddrWidth  : byte address width
//   Depth      : number of DataWidth-bit storage words
//   WaitStates : wait cycles per OKAY data phase (0-15)
//
// Ports
//   clk      in  : clock, all state changes on the rising edge
//   nReset   in  : asynchronous active-low reset
//   sel      in  : subordinate select from the address decoder
//   addr     in  : address-phase byte address
//   trans    in  : transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
//   write    in  : 1 = write, 0 = read
//   size     in  : log2 of the transfer size in bytes
//   wdata    in  : write data, valid during the data phase
//   ready    in  : bus-level ready; the previous transfer completes when 1
//   readyOut out : 0 extends the current data phase
//   resp     out : 0 OKAY, 1 ERROR
//   rdata    out : read data, non-zero only in a read's completing cycle
module ahb_sram_subordinate #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int Depth      = 256,
  parameter int WaitStates = 0
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 sel,
  input  logic [AddrWidth-1:0] addr,
  input  logic [1:0]           trans,
  input  logic                 write,
  input  logic [2:0]           size,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 ready,
  output logic                 readyOut,
  output logic                 resp,
  output logic [DataWidth-1:0] rdata
);

  localparam int NumBytes = DataWidth / 8;
  localparam int ByteBits = $clog2(NumBytes);
  localparam int IdxW     = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                 state_q;
  logic                   ready_out_q;
  logic                   resp_q;
  logic [3:0]             cnt_q;
  logic [AddrWidth-1:0]   addr_q;
  logic                   write_q;
  logic [2:0]             size_q;
  logic                   dp_valid_q;   // an OKAY transfer owns the data phase
  logic                   rd_en_q;      // rdata is live this cycle
  logic [NumBytes-1:0]    fwd_be_q;     // lanes taken from fwd_data_q
  logic [DataWidth-1:0]   fwd_data_q;
  logic [DataWidth-1:0]   rd_word_q;

  logic [DataWidth-1:0]   mem [Depth];

  logic                   accept_d;
  logic                   range_err_d;
  logic                   size_err_d;
  logic                   align_err_d;
  logic                   xfer_err_d;
  logic                   we_d;
  logic                   zw_rd_d;
  logic                   wait_rd_d;
  logic [IdxW-1:0]        widx_d;
  logic [IdxW-1:0]        ridx_d;
  logic [AddrWidth-1:0]   off_d;
  logic [NumBytes-1:0]    be_d;

  // The address phase is only sampled while the bus is ready; our own
  // readyOut gating keeps a held address from being taken mid-wait.
  assign accept_d = sel && ready && ready_out_q &&
                    ((trans == 2'd2) || (trans == 2'd3));

  assign range_err_d = (addr >> ByteBits) >= AddrWidth'(Depth);
  assign size_err_d  = size > 3'(ByteBits);
  assign align_err_d = (addr & ~({AddrWidth{1'b1}} << size)) != '0;
  assign xfer_err_d  = range_err_d || size_err_d || align_err_d;

  // A write commits on the edge that ends its readyOut=1 data-phase cycle.
  assign we_d   = ready_out_q && dp_valid_q && write_q;
  assign widx_d = IdxW'(addr_q >> ByteBits);
  assign off_d  = addr_q & AddrWidth'(NumBytes - 1);

  // Reads are fetched on the edge that opens their completing cycle:
  // the address edge itself with no wait states, else the last wait edge.
  assign zw_rd_d   = (WaitStates == 0) && accept_d && !xfer_err_d && !write;
  assign wait_rd_d = (state_q == S_WAIT) && (cnt_q == 4'd1) && !write_q;
  assign ridx_d    = (WaitStates == 0) ? IdxW'(addr >> ByteBits) : widx_d;

  // Little-endian lane enables for the transfer in the data phase.
  for (genvar gi = 0; gi < NumBytes; gi++) begin : g_be
    assign be_d[gi] = (AddrWidth'(gi) >= off_d) &&
                      (AddrWidth'(gi) < (off_d + (AddrWidth'(1) << size_q)));
  end

  // Storage: byte-lane writes, registered read-first port.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NumBytes; b++) begin
      if (we_d && be_d[b]) begin
        mem[widx_d][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rd_word_q <= mem[ridx_d];
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      ready_out_q <= 1'b1;
      resp_q      <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      dp_valid_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      fwd_be_q    <= '0;
      fwd_data_q  <= '0;
    end else begin
      rd_en_q    <= zw_rd_d || wait_rd_d;
      // A read issued on the same edge a write to that word commits sees
      // the old word from the RAM; patch in the freshly written lanes.
      fwd_be_q   <= (zw_rd_d && we_d && (ridx_d == widx_d)) ? be_d : '0;
      fwd_data_q <= wdata;

      case (state_q)
        S_IDLE, S_ERR2: begin
          if (accept_d) begin
            addr_q  <= addr;
            write_q <= write;
            size_q  <= size;
            if (xfer_err_d) begin
              state_q     <= S_ERR1;
              ready_out_q <= 1'b0;
              resp_q      <= 1'b1;
              dp_valid_q  <= 1'b0;
            end else if (WaitStates > 0) begin
              state_q     <= S_WAIT;
              cnt_q       <= 4'(WaitStates);
              ready_out_q <= 1'b0;
              resp_q      <= 1'b0;
              dp_valid_q  <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              ready_out_q <= 1'b1;
              resp_q      <= 1'b0;
              dp_valid_q  <= 1'b1;
            end
          end else begin
            state_q     <= S_IDLE;
            ready_out_q <= 1'b1;
            resp_q      <= 1'b0;
            dp_valid_q  <= 1'b0;
          end
        end
        S_WAIT: begin
          // The completing readyOut=1 cycle is spent back in IDLE with
          // dp_valid_q still set, so the write commits at its end.
          if (cnt_q <= 4'd1) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          ready_out_q <= 1'b1;
          resp_q      <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          ready_out_q <= 1'b1;
          resp_q      <= 1'b0;
          dp_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign readyOut = ready_out_q;
  assign resp     = resp_q;

  for (genvar gi = 0; gi < NumBytes; gi++) begin : g_rdata
    assign rdata[gi*8 +: 8] = !rd_en_q    ? 8'h00 :
                              fwd_be_q[gi] ? fwd_data_q[gi*8 +: 8] :
                                             rd_word_q[gi*8 +: 8];
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
module tb_ahb_sram_subordinate;
  localparam int DEP = 256;

  logic clk = 1'b0;
  logic nReset;
  logic [1:0]        sel_s;
  logic [1:0][31:0]  addr_s;
  logic [1:0][1:0]   trans_s;
  logic [1:0]        write_s;
  logic [1:0][2:0]   size_s;
  logic [1:0][31:0]  wdata_s;
  logic [1:0]        ready_s;
  logic [1:0]        ready_out_s;
  logic [1:0]        resp_s;
  logic [1:0][31:0]  rdata_s;

  always #5 clk = ~clk;

  // Single subordinate on each bus: bus ready follows its readyOut.
  assign ready_s = ready_out_s;

  ahb_sram_subordinate #(.DataWidth(32), .AddrWidth(32), .Depth(DEP), .WaitStates(0)) u_dut0 (
    .clk(clk), .nReset(nReset), .sel(sel_s[0]), .addr(addr_s[0]), .trans(trans_s[0]),
    .write(write_s[0]), .size(size_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]),
    .readyOut(ready_out_s[0]), .resp(resp_s[0]), .rdata(rdata_s[0]));

  ahb_sram_subordinate #(.DataWidth(32), .AddrWidth(32), .Depth(DEP), .WaitStates(3)) u_dut1 (
    .clk(clk), .nReset(nReset), .sel(sel_s[1]), .addr(addr_s[1]), .trans(trans_s[1]),
    .write(write_s[1]), .size(size_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]),
    .readyOut(ready_out_s[1]), .resp(resp_s[1]), .rdata(rdata_s[1]));

  typedef struct {
    int          inst;
    bit          err;
    logic [31:0] a;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        sb_q[$];
  byte unsigned ref_mem[2][DEP*4];
  int vectors = 0;
  int miscompares = 0;

  function automatic int ws_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    int unsigned au = a;
    int unsigned sb = 1 << sz;
    return ((au / 4) >= DEP) || (sz > 3'd2) || ((au % sb) != 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // Issue one NONSEQ transfer, hold it until accepted, then drive its wdata.
  task automatic issue(input int k, input bit wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd);
    exp_t e;
    int n;
    int base;
    int off;
    sel_s[k]   = 1'b1;
    addr_s[k]  = a;
    trans_s[k] = 2'd2;
    write_s[k] = wr;
    size_s[k]  = sz;
    e.inst  = k;
    e.a     = a;
    e.err   = is_err(a, sz);
    e.waits = e.err ? 1 : ws_of(k);
    e.rdata = '0;
    if (!e.err) begin
      base = int'(a) & ~3;
      off  = int'(a) & 3;
      if (wr) begin
        for (int b = 0; b < (1 << sz); b++) ref_mem[k][base + off + b] = wd[(off + b)*8 +: 8];
      end else begin
        for (int b = 0; b < 4; b++) e.rdata[b*8 +: 8] = ref_mem[k][base + b];
      end
    end
    sb_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!ready_out_s[k] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout inst%0d addr %h: readyOut stuck at %b, required 1", k, a, ready_out_s[k]);
    end
    @(posedge clk);
    #1;
    wdata_s[k] = wd;
    sel_s[k]   = 1'b0;
    trans_s[k] = 2'd0;
  endtask

  task automatic idle(input int k, input int n, input bit busy);
    sel_s[k]   = busy;
    trans_s[k] = busy ? 2'd1 : 2'd0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    sel_s[k]   = 1'b0;
    trans_s[k] = 2'd0;
  endtask

  // Watches one bus, times each data phase and scores it on completion.
  task automatic monitor(input int k);
    bit   in_dp = 1'b0;
    int   waits = 0;
    bit   wait_ok = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!nReset) begin
        in_dp = 1'b0;
        continue;
      end
      if (in_dp) begin
        if (!ready_out_s[k]) begin
          waits++;
          if (sb_q.size() > 0) begin
            if (resp_s[k] !== sb_q[0].err || rdata_s[k] !== 32'h0) wait_ok = 1'b0;
          end
        end else begin
          in_dp = 1'b0;
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_completion inst%0d: resp %b, no transfer outstanding", k, resp_s[k]);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("inst%0d @%h waits", k, e.a), waits, e.waits);
            check($sformatf("inst%0d @%h resp", k, e.a), {31'h0, resp_s[k]}, {31'h0, e.err});
            check($sformatf("inst%0d @%h rdata", k, e.a), rdata_s[k], e.rdata);
            check($sformatf("inst%0d @%h wait_cycle_outputs", k, e.a), {31'h0, wait_ok}, 32'h1);
          end
        end
      end
      if (sel_s[k] && ready_s[k] && trans_s[k][1]) begin
        in_dp   = 1'b1;
        waits   = 0;
        wait_ok = 1'b1;
      end
    end
  endtask

  task automatic random_traffic(input int k, input int n);
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(k, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      end else begin
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 1100));
        if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
        issue(k, 1'($urandom_range(0, 1)), a, sz, $urandom);
      end
    end
    idle(k, 8, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nReset  = 1'b0;
    sel_s   = '0;
    addr_s  = '0;
    trans_s = '0;
    write_s = '0;
    size_s  = '0;
    wdata_s = '0;
    fork
      monitor(0);
      monitor(1);
    join_none

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("inst%0d reset readyOut", k), {31'h0, ready_out_s[k]}, 32'h1);
      check($sformatf("inst%0d reset resp", k), {31'h0, resp_s[k]}, 32'h0);
      check($sformatf("inst%0d reset rdata", k), rdata_s[k], 32'h0);
    end
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;

    // Give every word a known value so all later reads are predictable.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < DEP; w++) issue(k, 1'b1, 32'(w * 4), 3'd2, $urandom);
      idle(k, 6, 1'b0);
    end

    // Zero-wait instance: back-to-back write/read, byte merge, errors, BUSY.
    issue(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h10, 3'd2, 32'h0);
    idle(0, 3, 1'b0);
    issue(0, 1'b1, 32'h10, 3'd2, 32'h11223344);
    issue(0, 1'b1, 32'h13, 3'd0, 32'hAA000000);
    issue(0, 1'b0, 32'h10, 3'd2, 32'h0);
    idle(0, 3, 1'b0);
    issue(0, 1'b1, 32'h400, 3'd2, 32'h12345678);
    issue(0, 1'b0, 32'h0, 3'd2, 32'h0);
    idle(0, 3, 1'b0);
    issue(0, 1'b0, 32'h11, 3'd1, 32'h0);
    idle(0, 4, 1'b0);
    sel_s[0]   = 1'b1;
    trans_s[0] = 2'd1;
    @(posedge clk);
    #1;
    sel_s[0]   = 1'b0;
    trans_s[0] = 2'd0;
    @(negedge clk);
    check("inst0 busy readyOut", {31'h0, ready_out_s[0]}, 32'h1);
    check("inst0 busy resp", {31'h0, resp_s[0]}, 32'h0);

    // Three-wait instance: plain read, then out-of-range write and read of 0.
    issue(1, 1'b0, 32'h10, 3'd2, 32'h0);
    idle(1, 8, 1'b0);
    issue(1, 1'b1, 32'h400, 3'd2, 32'hCAFEF00D);
    issue(1, 1'b0, 32'h0, 3'd2, 32'h0);
    idle(1, 8, 1'b0);

    random_traffic(0, 60);
    random_traffic(1, 40);

    // Reset during the second wait cycle of a write must abort it.
    issue(1, 1'b1, 32'h20, 3'd2, 32'h55667788);
    idle(1, 8, 1'b0);
    sel_s[1]   = 1'b1;
    addr_s[1]  = 32'h20;
    trans_s[1] = 2'd2;
    write_s[1] = 1'b1;
    size_s[1]  = 3'd2;
    @(posedge clk);
    #1;
    wdata_s[1] = 32'h99999999;
    sel_s[1]   = 1'b0;
    trans_s[1] = 2'd0;
    @(posedge clk);
    #2;
    nReset = 1'b0;
    #1;
    check("inst1 mid-wait reset readyOut", {31'h0, ready_out_s[1]}, 32'h1);
    check("inst1 mid-wait reset resp", {31'h0, resp_s[1]}, 32'h0);
    check("inst1 mid-wait reset rdata", rdata_s[1], 32'h0);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h20, 3'd2, 32'h0);
    idle(1, 8, 1'b0);

    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    if (sb_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d transfers never completed, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_sram_subordinate.md
AHB_SRAM_SUBORDINATE -- requirements
Module: ahb_sram_subordinate

Interface
REQ-001 SHALL have parameter DataWidth, default 32, bit-width of data transfers (8, 16, 32 or 64).
REQ-002 SHALL have parameter AddrWidth, default 32, bit-width of an address.
REQ-003 SHALL have parameter Depth, default 256, number of DataWidth-bit storage words.
REQ-004 SHALL have parameter WaitStates, default 0, wait cycles inserted per OKAY data phase (0-15).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-007 SHALL have port nReset, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port sel, input, 1 bit: select for this subordinate, one bit of the address decoder output.
REQ-009 SHALL have port addr, input, AddrWidth bits: address-phase byte address.
REQ-010 SHALL have port trans, input, 2 bits: transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
REQ-011 SHALL have port write, input, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL have port size, input, 3 bits: log2 of the transfer bytes.
REQ-013 SHALL have port wdata, input, DataWidth bits: write data, valid in the data phase.
REQ-014 SHALL have port ready, input, 1 bit: bus-level HREADY; the previous transfer completes when it is 1.
REQ-015 SHALL have port readyOut, output, 1 bit: 0 extends the current data phase.
REQ-016 SHALL have port resp, output, 1 bit: 0 OKAY, 1 ERROR.
REQ-017 SHALL have port rdata, output, DataWidth bits: read data.

Function
REQ-018 SHALL accept an address phase only when sel=1, ready=1 and trans is NONSEQ or SEQ; it SHALL register addr, write and size on that edge.
REQ-019 SHALL answer IDLE/BUSY transfers and unselected cycles with zero-wait OKAY: readyOut=1, resp=0, no storage access.
REQ-020 SHALL classify an accepted transfer as an error if any of the following holds: word index addr/(DataWidth/8) >= Depth; size > log2(DataWidth/8); addr not aligned to 2^size.
REQ-021 SHALL implement the FSM states IDLE, WAIT, ERR1 and ERR2.
REQ-022 SHALL move IDLE->WAIT on an accepted OKAY transfer when WaitStates>0.
REQ-023 SHALL complete an accepted OKAY transfer in the next cycle when WaitStates=0 (readyOut=1, resp=0) and SHALL remain in IDLE.
REQ-024 SHALL, in WAIT, drive readyOut=0 and resp=0 for exactly WaitStates cycles using a down-counter, then give one cycle with readyOut=1 and return to IDLE.
REQ-025 SHALL move from IDLE to ERR1 on an accepted error transfer, with no wait states.
REQ-026 SHALL, in ERR1, drive readyOut=0 and resp=1, and SHALL move to ERR2.
REQ-027 SHALL, in ERR2, drive readyOut=1 and resp=1, and SHALL move to IDLE.
REQ-028 SHALL NOT modify storage for an errored transfer.
REQ-029 SHALL commit a write on the edge ending the data phase (the readyOut=1 cycle), using wdata sampled on that edge.
REQ-030 SHALL update only the byte lanes selected by size and the low address bits (little-endian); other bytes SHALL be kept.
REQ-031 SHALL drive rdata with the full addressed word during the completing cycle of a read data phase, and SHALL drive 0 in all other cycles.
REQ-032 SHALL allow a new address phase in the completing cycle of the previous transfer (pipelined, back-to-back).
REQ-033 SHALL return, for a read that directly follows a write to the same word, the data just written.
REQ-034 SHALL ignore sel and trans while readyOut=0; these are sampled only when ready=1.

Reset
REQ-035 SHALL, while nReset=0, force state IDLE, readyOut=1, resp=0, rdata=0, wait counter=0, and clear the registered address-phase fields.
REQ-036 SHALL abort an in-progress transfer on reset without committing any write.
REQ-037 SHALL leave storage contents undefined after reset; storage is not cleared.

Verification
REQ-038 SHALL pass this scenario: WaitStates=0, word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> both complete with one readyOut=1 cycle each, and rdata=0xDEADBEEF.
REQ-039 SHALL pass this scenario: byte write 0xAA to 0x13 over an existing 0x11223344 at 0x10 -> a word read of 0x10 returns 0xAA223344.
REQ-040 SHALL pass this scenario: WaitStates=3, read -> readyOut=0 for 3 cycles, then readyOut=1 with valid rdata and resp=0.
REQ-041 SHALL pass this scenario: Depth=256, write to 0x400 -> readyOut=0/resp=1 then readyOut=1/resp=1, and a later read of 0x0 is unchanged.
REQ-042 SHALL pass this scenario: halfword access at 0x11 -> two-cycle ERROR response; trans=BUSY with sel=1 -> OKAY with zero wait.
REQ-043 SHALL pass this scenario: nReset asserted in the second WAIT cycle of a write -> readyOut=1, resp=0 immediately, and the target word is unchanged.
